// File: rtl/serv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serv_pkg
//  Description : Shared constants and elaboration helpers for the W-wide
//                bit-serial datapath blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package serv_pkg;

    localparam int XLEN = 32;

    // Number of W-bit beats that make up one XLEN word.
    function automatic int beats(input int w);
        return XLEN / w;
    endfunction

    // Ceiling log2, used to size the beat counter.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Datapath widths supported by the serial blocks.
    function automatic bit legal_w(input int w);
        return (w == 1) || (w == 2) || (w == 4) || (w == 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serv_beat_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : serv_beat_cnt
//  Description : Beat position counter for W-wide serial blocks. A start
//                pulse forces the current beat to be treated as beat 0; each
//                enabled beat advances the count, wrapping after N-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module serv_beat_cnt #(
    parameter int N  = 32,
    parameter int CW = 5
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_en,
    output logic [CW-1:0] o_be,
    output logic          o_last
);

    localparam logic [CW-1:0] C_LAST = CW'(N - 1);

    logic [CW-1:0] r_beat_q;
    logic [CW-1:0] w_beat_d;

    // A start pulse overrides the stored position for the current cycle.
    assign o_be   = i_start ? '0 : r_beat_q;
    assign o_last = (o_be == C_LAST);

    // Next beat: advance on enable (wrapping at N-1), clear on a bare start.
    always_comb begin
        w_beat_d = r_beat_q;
        if (i_en) begin
            w_beat_d = o_last ? '0 : (o_be + CW'(1));
        end else if (i_start) begin
            w_beat_d = '0;
        end
    end

    // Beat position register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_beat_q <= '0;
        end else begin
            r_beat_q <= w_beat_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/serv_bufreg_w.sv
`default_nettype none
// ============================================================================
//  Module      : serv_bufreg_w
//  Description : W-bit-per-beat serial buffer register. Adds rs1 and imm
//                slices with a beat-to-beat carry, shifts the sum into a
//                32-bit register, captures address bits [1:0] and can
//                recirculate its contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module serv_bufreg_w
    import serv_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic         i_en,
    input  logic         i_init,
    input  logic         i_loop,
    input  logic [W-1:0] i_rs1,
    input  logic         i_rs1_en,
    input  logic [W-1:0] i_imm,
    input  logic         i_imm_en,
    output logic [1:0]   o_lsb,
    output logic [31:0]  o_reg,
    output logic [W-1:0] o_q,
    output logic         o_last,
    output logic         o_done
);

    localparam int N  = beats(W);
    localparam int CW = clog2(N);

    if (!legal_w(W)) begin : g_bad_w
        $error("serv_bufreg_w: W must be 1, 2, 4 or 8");
    end

    logic [XLEN-1:0] r_data_q;
    logic            r_carry_q;
    logic [1:0]      r_lsb_q;
    logic            r_done_q;

    logic [CW-1:0]   w_be;
    logic            w_last;
    logic [W-1:0]    w_a;
    logic [W-1:0]    w_b;
    logic            w_cin;
    logic [W:0]      w_sum;
    logic [W-1:0]    w_in;

    serv_beat_cnt #(
        .N  (N),
        .CW (CW)
    ) u_beat_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_en    (i_en),
        .o_be    (w_be),
        .o_last  (w_last)
    );

    // Gated operands and the carry-extended slice sum.
    assign w_a   = i_rs1 & {W{i_rs1_en}};
    assign w_b   = i_imm & {W{i_imm_en}};
    assign w_cin = i_start ? 1'b0 : r_carry_q;
    assign w_sum = {1'b0, w_a} + {1'b0, w_b} + {{W{1'b0}}, w_cin};

    // Loop mode feeds the outgoing slice back in; init always takes the sum.
    assign w_in  = (i_loop & ~i_init) ? r_data_q[W-1:0] : w_sum[W-1:0];

    // Shift register: new slice enters at the top, LSB slice leaves at o_q.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data_q <= '0;
        end else if (i_en) begin
            r_data_q <= {w_in, r_data_q[XLEN-1:W]};
        end
    end

    // Carry is kept only during init and dropped at the word boundary.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_carry_q <= 1'b0;
        end else if (i_en) begin
            r_carry_q <= w_sum[W] & i_init & ~w_last;
        end else if (i_start) begin
            r_carry_q <= 1'b0;
        end
    end

    // Done pulses the cycle after the last beat has been shifted in.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_done_q <= 1'b0;
        end else begin
            r_done_q <= i_en & w_last;
        end
    end

    if (W == 1) begin : g_lsb_w1
        // Single-bit datapath: the two LSBs arrive on beats 0 and 1.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_lsb_q <= 2'b00;
            end else if (i_en & i_init) begin
                if (w_be == CW'(0)) begin
                    r_lsb_q[0] <= w_sum[0];
                end else if (w_be == CW'(1)) begin
                    r_lsb_q[1] <= w_sum[0];
                end
            end
        end
    end else begin : g_lsb_wide
        // Wider datapath: both LSBs are present in beat 0.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_lsb_q <= 2'b00;
            end else if (i_en & i_init & (w_be == CW'(0))) begin
                r_lsb_q <= w_sum[1:0];
            end
        end
    end

    assign o_lsb  = r_lsb_q;
    assign o_reg  = r_data_q;
    assign o_q    = r_data_q[W-1:0];
    assign o_last = w_last;
    assign o_done = r_done_q;

endmodule
`default_nettype wire

// File: tb/tb_serv_bufreg_w.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serv_bufreg_w
//  Description : Self-checking bench for serv_bufreg_w at W = 1, 2, 4, 8.
//                Index k selects the instance with W = 1 << k.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serv_bufreg_w;

    logic       clk;
    logic       rst;
    logic [3:0] st, en, ini, lp, r1e, ime;
    logic [7:0] rs1 [4];
    logic [7:0] imm [4];

    logic [31:0] oreg [4];
    logic [1:0]  olsb [4];
    logic [3:0]  olast, odone;
    logic        q1;
    logic [1:0]  q2;
    logic [3:0]  q4;
    logic [7:0]  q8;

    // Reference state: expected register, expected LSBs, and whether the
    // expected register is known (a partial word leaves it undefined).
    logic [31:0] mreg  [4];
    logic [1:0]  mlsb  [4];
    bit          mvalid[4];

    int n_chk  = 0;
    int n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serv_bufreg_w #(.W(1)) u_w1 (
        .i_clk(clk), .i_rst(rst), .i_start(st[0]), .i_en(en[0]), .i_init(ini[0]),
        .i_loop(lp[0]), .i_rs1(rs1[0][0:0]), .i_rs1_en(r1e[0]), .i_imm(imm[0][0:0]),
        .i_imm_en(ime[0]), .o_lsb(olsb[0]), .o_reg(oreg[0]), .o_q(q1),
        .o_last(olast[0]), .o_done(odone[0]));

    serv_bufreg_w #(.W(2)) u_w2 (
        .i_clk(clk), .i_rst(rst), .i_start(st[1]), .i_en(en[1]), .i_init(ini[1]),
        .i_loop(lp[1]), .i_rs1(rs1[1][1:0]), .i_rs1_en(r1e[1]), .i_imm(imm[1][1:0]),
        .i_imm_en(ime[1]), .o_lsb(olsb[1]), .o_reg(oreg[1]), .o_q(q2),
        .o_last(olast[1]), .o_done(odone[1]));

    serv_bufreg_w #(.W(4)) u_w4 (
        .i_clk(clk), .i_rst(rst), .i_start(st[2]), .i_en(en[2]), .i_init(ini[2]),
        .i_loop(lp[2]), .i_rs1(rs1[2][3:0]), .i_rs1_en(r1e[2]), .i_imm(imm[2][3:0]),
        .i_imm_en(ime[2]), .o_lsb(olsb[2]), .o_reg(oreg[2]), .o_q(q4),
        .o_last(olast[2]), .o_done(odone[2]));

    serv_bufreg_w #(.W(8)) u_w8 (
        .i_clk(clk), .i_rst(rst), .i_start(st[3]), .i_en(en[3]), .i_init(ini[3]),
        .i_loop(lp[3]), .i_rs1(rs1[3]), .i_rs1_en(r1e[3]), .i_imm(imm[3]),
        .i_imm_en(ime[3]), .o_lsb(olsb[3]), .o_reg(oreg[3]), .o_q(q8),
        .o_last(olast[3]), .o_done(odone[3]));

    function automatic logic [31:0] getq(input int k);
        case (k)
            0:       return {31'b0, q1};
            1:       return {30'b0, q2};
            2:       return {28'b0, q4};
            default: return {24'b0, q8};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
            $error("%s mismatch", tag);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            mreg[k]   = 32'h0;
            mlsb[k]   = 2'b00;
            mvalid[k] = 1'b1;
        end
    endtask

    // One full word on instance k; the counter must be at beat 0 or dostart set.
    task automatic run_word(input int k, input logic [31:0] a_in, input logic [31:0] b_in,
                            input bit r1en, input bit imen, input bit inn, input bit lpp,
                            input bit dostart);
        int          w;
        int          n;
        logic [31:0] mask;
        logic [31:0] am, bm, nr;
        w    = 1 << k;
        n    = 32 / w;
        mask = (32'd1 << w) - 32'd1;
        for (int b = 0; b < n; b++) begin
            rs1[k] = 8'((a_in >> (b * w)) & mask);
            imm[k] = 8'((b_in >> (b * w)) & mask);
            en[k]  = 1'b1;
            st[k]  = dostart && (b == 0);
            ini[k] = inn;
            lp[k]  = lpp;
            r1e[k] = r1en;
            ime[k] = imen;
            #1;
            chk("last", {31'b0, olast[k]}, {31'b0, b == n - 1});
            chk("done_low", {31'b0, odone[k]}, 32'h0);
            if (mvalid[k]) chk("q_slice", getq(k), (mreg[k] >> (b * w)) & mask);
            @(posedge clk);
            @(negedge clk);
        end
        en[k] = 1'b0;
        st[k] = 1'b0;
        am = r1en ? a_in : 32'h0;
        bm = imen ? b_in : 32'h0;
        if (inn) begin
            nr      = am + bm;
            mlsb[k] = nr[1:0];
        end else if (lpp) begin
            nr = mreg[k];
        end else begin
            nr = 32'h0;
            for (int j = 0; j < n; j++) begin
                nr |= ((((am >> (j * w)) & mask) + ((bm >> (j * w)) & mask)) & mask) << (j * w);
            end
        end
        mreg[k]   = nr;
        mvalid[k] = 1'b1;
        #1;
        chk("done_pulse", {31'b0, odone[k]}, 32'h1);
        chk("reg", oreg[k], mreg[k]);
        chk("lsb", {30'b0, olsb[k]}, {30'b0, mlsb[k]});
        @(posedge clk);
        @(negedge clk);
        chk("done_drop", {31'b0, odone[k]}, 32'h0);
    endtask

    // Abandoned word fragment with init off, leaving the register undefined.
    task automatic partial(input int k, input int nb, input bit dostart);
        for (int b = 0; b < nb; b++) begin
            rs1[k] = 8'($urandom);
            imm[k] = 8'($urandom);
            en[k]  = 1'b1;
            st[k]  = dostart && (b == 0);
            ini[k] = 1'b0;
            lp[k]  = 1'b0;
            r1e[k] = 1'b1;
            ime[k] = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        en[k]     = 1'b0;
        st[k]     = 1'b0;
        mvalid[k] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        st = '0; en = '0; ini = '0; lp = '0; r1e = '0; ime = '0;
        for (int k = 0; k < 4; k++) begin
            rs1[k] = '0;
            imm[k] = '0;
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rst_reg", oreg[k], 32'h0);
            chk("rst_lsb", {30'b0, olsb[k]}, 32'h0);
            chk("rst_done", {31'b0, odone[k]}, 32'h0);
            chk("rst_last", {31'b0, olast[k]}, 32'h0);
        end
        @(negedge clk);

        // Directed words.
        run_word(2, 32'h00001003, 32'h00000FFD, 1, 1, 1, 0, 1);
        chk("t1_reg", oreg[2], 32'h00002000);
        run_word(0, 32'h80000002, 32'h00000001, 1, 1, 1, 0, 1);
        chk("t2_lsb", {30'b0, olsb[0]}, 32'h3);
        run_word(3, 32'hFFFFFFFF, 32'h00000001, 1, 1, 1, 0, 1);
        run_word(3, 32'h0, 32'h0, 1, 1, 1, 0, 0);
        chk("t3_noleak", oreg[3], 32'h0);
        run_word(2, 32'h12345678, 32'h0, 1, 1, 1, 0, 1);
        run_word(2, 32'h0, 32'h0, 0, 0, 0, 1, 1);
        chk("t4_loop", oreg[2], 32'h12345678);
        run_word(1, 32'hFFFFFFFF, 32'h00000006, 0, 1, 1, 0, 1);
        chk("t5_lsb", {30'b0, olsb[1]}, 32'h2);
        run_word(1, 32'hFFFFFFFF, 32'h00000006, 0, 0, 1, 0, 1);
        run_word(1, 32'h00000005, 32'h00000006, 1, 1, 0, 0, 1);

        // Reset mid-word on the W=4 instance at beat 3.
        partial(2, 3, 1);
        rs1[2] = 8'h9; imm[2] = 8'h7; en[2] = 1'b1; ini[2] = 1'b1; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; en[2] = 1'b0; ini[2] = 1'b0;
        model_reset();
        #1;
        chk("mrst_reg", oreg[2], 32'h0);
        chk("mrst_lsb", {30'b0, olsb[2]}, 32'h0);
        chk("mrst_done", {31'b0, odone[2]}, 32'h0);
        chk("mrst_last", {31'b0, olast[2]}, 32'h0);
        @(negedge clk);
        run_word(2, 32'hDEADBEEF, 32'h01234567, 1, 1, 1, 0, 0);
        partial(2, 3, 0);
        run_word(2, 32'hCAFEF00D, 32'h11111111, 1, 1, 1, 0, 1);

        // Randomized words across all widths.
        for (int it = 0; it < 40; it++) begin
            int k;
            bit lpp;
            bit dostart;
            k       = int'($urandom_range(0, 3));
            lpp     = bit'($urandom_range(0, 1)) && mvalid[k];
            dostart = bit'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) begin
                partial(k, int'($urandom_range(1, 3)), 0);
                lpp     = 1'b0;
                dostart = 1'b1;
            end
            run_word(k, $urandom, $urandom, bit'($urandom_range(0, 1)),
                     bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), lpp, dostart);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
